// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, types and helpers for the double-buffered
// 16x16 pixel store.
//   FB_W, FB_H  : frame dimensions in pixels
//   FB_AW       : address width of one bank ({y, x})
//   FB_LEVEL_W  : default bits per pixel
//   level_t     : one pixel brightness value
//   fb_state_e  : controller states
//   fb_addr()   : pixel coordinate to bank address
package fb_pkg;

   localparam int FB_W       = 16;
   localparam int FB_H       = 16;
   localparam int FB_AW      = 8;
   localparam int FB_LEVEL_W = 2;

   typedef logic [FB_LEVEL_W-1:0] level_t;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      CLEAR,
      SWAP_WAIT
   } fb_state_e;

   function automatic logic [FB_AW-1:0] fb_addr(input logic [3:0] x,
                                                input logic [3:0] y);
      return {y, x};
   endfunction

endpackage

// File: rtl/fb_bank.sv
// fb_bank: one 2^AW x W pixel bank.
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset (clears the read register only)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : registered read data, one cycle after raddr
module fb_bank #(
   parameter int W  = 2,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [0:(1<<AW)-1];

   // Storage itself is not reset; the controller initialises it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/fb_double_buffer.sv
// fb_double_buffer: double-buffered 16x16 pixel store feeding the matrix
// scanner. Drawing logic writes the back buffer; the scanner reads the
// front buffer. A swap takes effect only on a scanner frame_end, and the
// back buffer can be cleared in hardware.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   wr_valid/wr_ready     : pixel write handshake
//   wr_x, wr_y, wr_level  : write coordinate and value (into back buffer)
//   clr_req               : pulse, fill back buffer with CLEAR_LEVEL
//   swap_req              : pulse, exchange buffers at the next frame_end
//   frame_end             : pulse from scanner at end of a frame
//   busy                  : controller not idle
//   swap_ack              : pulse on the cycle the swap takes effect
//   rd_x, rd_y, rd_level  : scanner read of front buffer, 1-cycle latency
//   front_sel             : index of the current front bank
//   frame_cnt             : number of completed swaps (wrapping)
module fb_double_buffer
   import fb_pkg::*;
#(
   parameter int                 LEVEL_W     = 2,
   parameter logic [LEVEL_W-1:0] CLEAR_LEVEL = '0,
   parameter int                 FCNT_W      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [3:0]         wr_x,
   input  logic [3:0]         wr_y,
   input  logic [LEVEL_W-1:0] wr_level,
   input  logic               clr_req,
   input  logic               swap_req,
   input  logic               frame_end,
   output logic               busy,
   output logic               swap_ack,
   input  logic [3:0]         rd_x,
   input  logic [3:0]         rd_y,
   output logic [LEVEL_W-1:0] rd_level,
   output logic               front_sel,
   output logic [FCNT_W-1:0]  frame_cnt
);

   fb_state_e          state, state_nxt;
   logic [FB_AW-1:0]   cnt;
   logic               rd_sel;
   logic               we0, we1;
   logic [FB_AW-1:0]   waddr;
   logic [LEVEL_W-1:0] wdata;
   logic [LEVEL_W-1:0] rdata0, rdata1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wr_ready  = 1'b0;
      we0       = 1'b0;
      we1       = 1'b0;
      waddr     = fb_addr(wr_x, wr_y);
      wdata     = wr_level;
      case (state)
         INIT: begin
            we0   = 1'b1;
            we1   = 1'b1;
            waddr = cnt;
            wdata = CLEAR_LEVEL;
            if (cnt == '1) state_nxt = IDLE;
         end
         IDLE: begin
            wr_ready = !clr_req && !swap_req;
            if (wr_valid && wr_ready) begin
               we0 = front_sel;
               we1 = !front_sel;
            end
            if (clr_req)       state_nxt = CLEAR;
            else if (swap_req) state_nxt = SWAP_WAIT;
         end
         CLEAR: begin
            we0   = front_sel;
            we1   = !front_sel;
            waddr = cnt;
            wdata = CLEAR_LEVEL;
            if (cnt == '1) state_nxt = IDLE;
         end
         SWAP_WAIT: begin
            if (frame_end) state_nxt = IDLE;
         end
         default: state_nxt = INIT;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         front_sel <= 1'b0;
         frame_cnt <= '0;
         swap_ack  <= 1'b0;
         rd_sel    <= 1'b0;
      end else begin
         swap_ack <= 1'b0;
         // Remember which bank the in-flight read came from so the read
         // on the swap edge still returns the old front.
         rd_sel   <= front_sel;
         case (state)
            INIT, CLEAR: cnt <= cnt + 1'b1;
            IDLE:        cnt <= '0;
            SWAP_WAIT: begin
               if (frame_end) begin
                  front_sel <= !front_sel;
                  frame_cnt <= frame_cnt + 1'b1;
                  swap_ack  <= 1'b1;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

   fb_bank #(.W(LEVEL_W), .AW(FB_AW)) u_bank0 (
      .clk   (clk),
      .rst   (rst),
      .we    (we0),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (fb_addr(rd_x, rd_y)),
      .rdata (rdata0)
   );

   fb_bank #(.W(LEVEL_W), .AW(FB_AW)) u_bank1 (
      .clk   (clk),
      .rst   (rst),
      .we    (we1),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (fb_addr(rd_x, rd_y)),
      .rdata (rdata1)
   );

   assign rd_level = rd_sel ? rdata1 : rdata0;

endmodule

// File: tb/tb_fb_double_buffer.sv
module tb_fb_double_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [3:0] wr_x = '0;
   logic [3:0] wr_y = '0;
   logic [1:0] wr_level = '0;
   logic       clr_req = 1'b0;
   logic       swap_req = 1'b0;
   logic       frame_end = 1'b0;
   logic       busy;
   logic       swap_ack;
   logic [3:0] rd_x = '0;
   logic [3:0] rd_y = '0;
   logic [1:0] rd_level;
   logic       front_sel;
   logic [7:0] frame_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fb_double_buffer #(
      .LEVEL_W     (2),
      .CLEAR_LEVEL (2'd0),
      .FCNT_W      (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .wr_level  (wr_level),
      .clr_req   (clr_req),
      .swap_req  (swap_req),
      .frame_end (frame_end),
      .busy      (busy),
      .swap_ack  (swap_ack),
      .rd_x      (rd_x),
      .rd_y      (rd_y),
      .rd_level  (rd_level),
      .front_sel (front_sel),
      .frame_cnt (frame_cnt)
   );

   // ---------------- behavioural model ----------------
   // Busy periods are countdowns; a clear is modelled as an instant fill of
   // the back image since nothing can observe or write it until it ends.
   bit         m_started = 0;
   int         m_init_left = 0;
   int         m_clear_left = 0;
   bit         m_swap_pend = 0;
   bit         m_front = 0;
   bit         m_ack = 0;
   bit         m_rd_known = 0;
   logic [1:0] m_rd = '0;
   logic [7:0] m_fcnt = '0;
   logic [1:0] m_img [2][256];

   function automatic bit m_idle();
      return (m_init_left == 0) && (m_clear_left == 0) && !m_swap_pend;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_started    = 1;
         m_init_left  = 256;
         m_clear_left = 0;
         m_swap_pend  = 0;
         m_front      = 0;
         m_fcnt       = '0;
         m_ack        = 0;
         m_rd         = '0;
         m_rd_known   = 1;
         for (int a = 0; a < 256; a++) begin
            m_img[0][a] = 2'd0;
            m_img[1][a] = 2'd0;
         end
      end else if (m_started) begin
         m_rd_known = (m_init_left == 0);
         m_rd       = m_img[m_front][{rd_y, rd_x}];
         m_ack      = 0;
         if (m_init_left > 0) begin
            m_init_left--;
         end else if (m_clear_left > 0) begin
            m_clear_left--;
         end else if (m_swap_pend) begin
            if (frame_end) begin
               m_front     = !m_front;
               m_fcnt      = m_fcnt + 8'd1;
               m_ack       = 1;
               m_swap_pend = 0;
            end
         end else if (clr_req) begin
            for (int a = 0; a < 256; a++) m_img[!m_front][a] = 2'd0;
            m_clear_left = 256;
         end else if (swap_req) begin
            m_swap_pend = 1;
         end else if (wr_valid) begin
            m_img[!m_front][{wr_y, wr_x}] = wr_level;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare process: inputs change 1 time unit after posedge, so negedge
   // sees settled registered outputs and the combinational wr_ready.
   always @(negedge clk) begin
      if (m_started) begin
         chk("busy", {31'd0, busy}, {31'd0, !m_idle()});
         chk("wr_ready", {31'd0, wr_ready},
             {31'd0, m_idle() && !clr_req && !swap_req});
         chk("swap_ack", {31'd0, swap_ack}, {31'd0, m_ack});
         chk("front_sel", {31'd0, front_sel}, {31'd0, m_front});
         chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, m_fcnt});
         if (m_rd_known) chk("rd_level", {30'd0, rd_level}, {30'd0, m_rd});
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic busy_len(input string nm, input int exp);
      int n = 0;
      while (busy !== 1'b0 && n < 1000) begin
         n++;
         cyc(1);
      end
      chk(nm, n, exp);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 1000) begin
         n++;
         cyc(1);
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic read_all();
      for (int a = 0; a < 256; a++) begin
         rd_x = 4'(a);
         rd_y = 4'(a >> 4);
         cyc(1);
      end
      cyc(1);
   endtask

   task automatic do_swap(input int gap);
      swap_req = 1'b1;
      cyc(1);
      swap_req = 1'b0;
      cyc(gap);
      frame_end = 1'b1;
      cyc(1);
      frame_end = 1'b0;
   endtask

   task automatic reset_literals(input string nm);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
      chk({nm, "_ready"}, {31'd0, wr_ready}, 32'd0);
      chk({nm, "_ack"}, {31'd0, swap_ack}, 32'd0);
      chk({nm, "_rd"}, {30'd0, rd_level}, 32'd0);
      chk({nm, "_front"}, {31'd0, front_sel}, 32'd0);
      chk({nm, "_fcnt"}, {24'd0, frame_cnt}, 32'd0);
   endtask

   initial begin
      // reset and init
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      reset_literals("rst0");
      busy_len("init_len", 256);
      for (int a = 0; a < 256; a++) begin
         rd_x = 4'(a);
         rd_y = 4'(a >> 4);
         cyc(1);
         chk("init_zero", {30'd0, rd_level}, 32'd0);
      end

      // single pixel write then swap
      wr_x = 4'd3; wr_y = 4'd5; wr_level = 2'd2; wr_valid = 1'b1;
      cyc(1);
      wr_valid = 1'b0;
      do_swap(9);
      chk("swap_ack_pulse", {31'd0, swap_ack}, 32'd1);
      chk("swap_front", {31'd0, front_sel}, 32'd1);
      chk("swap_fcnt", {24'd0, frame_cnt}, 32'd1);
      rd_x = 4'd3; rd_y = 4'd5;
      cyc(1);
      chk("pixel_3_5", {30'd0, rd_level}, 32'd2);
      chk("swap_ack_one", {31'd0, swap_ack}, 32'd0);
      read_all();

      // frame_end coincident with swap_req does not count
      swap_req = 1'b1; frame_end = 1'b1;
      cyc(1);
      swap_req = 1'b0; frame_end = 1'b0;
      chk("no_early_swap", {31'd0, front_sel}, 32'd1);
      wr_valid = 1'b1;
      for (int i = 0; i < 39; i++) begin
         wr_x = 4'($urandom); wr_y = 4'($urandom); wr_level = 2'($urandom);
         cyc(1);
         chk("ready_in_wait", {31'd0, wr_ready}, 32'd0);
      end
      wr_valid = 1'b0;
      frame_end = 1'b1;
      cyc(1);
      frame_end = 1'b0;
      chk("late_swap_ack", {31'd0, swap_ack}, 32'd1);
      chk("late_swap_front", {31'd0, front_sel}, 32'd0);
      read_all();

      // fill back with 3, clear, write held through the clear
      wr_valid = 1'b1; wr_level = 2'd3;
      for (int a = 0; a < 256; a++) begin
         wr_x = 4'(a); wr_y = 4'(a >> 4);
         cyc(1);
      end
      wr_valid = 1'b0;
      clr_req = 1'b1;
      cyc(1);
      clr_req = 1'b0;
      wr_valid = 1'b1; wr_x = 4'd1; wr_y = 4'd1; wr_level = 2'd3;
      busy_len("clear_len", 256);
      cyc(1);
      wr_valid = 1'b0;
      do_swap(4);
      rd_x = 4'd1; rd_y = 4'd1;
      cyc(1);
      chk("held_write", {30'd0, rd_level}, 32'd3);
      rd_x = 4'd0; rd_y = 4'd0;
      cyc(1);
      chk("cleared_px", {30'd0, rd_level}, 32'd0);
      read_all();

      // clr_req and swap_req together: clear wins, swap dropped
      clr_req = 1'b1; swap_req = 1'b1; wr_valid = 1'b1;
      wr_x = 4'd2; wr_y = 4'd2; wr_level = 2'd1;
      #1;
      chk("ready_clr_swap", {31'd0, wr_ready}, 32'd0);
      cyc(1);
      clr_req = 1'b0; swap_req = 1'b0; wr_valid = 1'b0;
      wait_idle();
      cyc(3);
      frame_end = 1'b1;
      cyc(1);
      frame_end = 1'b0;
      cyc(1);
      chk("swap_dropped", {31'd0, front_sel}, 32'd1);
      chk("swap_dropped_cnt", {24'd0, frame_cnt}, 32'd3);

      // reset during SWAP_WAIT and during CLEAR
      swap_req = 1'b1;
      cyc(1);
      swap_req = 1'b0;
      cyc(5);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      reset_literals("rst_swap");
      busy_len("init_len2", 256);
      clr_req = 1'b1;
      cyc(1);
      clr_req = 1'b0;
      cyc(50);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      reset_literals("rst_clear");
      busy_len("init_len3", 256);

      // frame counter wrap
      for (int i = 0; i < 256; i++) do_swap(1);
      cyc(1);
      chk("fcnt_wrap", {24'd0, frame_cnt}, 32'd0);
      chk("front_after_wrap", {31'd0, front_sel}, 32'd0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         wr_valid  = 1'($urandom_range(0, 1));
         wr_x      = 4'($urandom); wr_y = 4'($urandom);
         wr_level  = 2'($urandom);
         rd_x      = 4'($urandom); rd_y = 4'($urandom);
         clr_req   = ($urandom_range(0, 199) == 0);
         swap_req  = ($urandom_range(0, 14) == 0);
         frame_end = ($urandom_range(0, 24) == 0);
         rst       = ($urandom_range(0, 2999) == 0);
         cyc(1);
      end
      rst = 1'b0; wr_valid = 1'b0; clr_req = 1'b0; swap_req = 1'b0;
      frame_end = 1'b1;
      cyc(1);
      frame_end = 1'b0;
      wait_idle();
      read_all();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
